// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding, reset divisor and the phase-end compare
// used by the programmable clock divider.
`timescale 1ns/1ps
package clkdiv_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_LOW  = ST_LOW,
      S_HIGH = ST_HIGH
   } state_t;

   // Half-period divisor after reset: 27 MHz / (2*13) ~= 1.038 MHz.
   localparam int CLKDIV_DEFAULT_DIV = 13;

   // True on the last cycle of a phase. A divisor of 0 is clamped to 1 here so
   // the clamp lives in exactly one place. Callers zero-extend to 32 bits.
   function automatic logic phase_end(input logic [31:0] cnt, input logic [31:0] div);
      logic [31:0] neff;
      neff = (div == 32'd0) ? 32'd1 : div;
      return (cnt == neff - 32'd1);
   endfunction

endpackage

// File: rtl/clkdiv_phase_counter.sv
// clkdiv_phase_counter: phase counter with clear/hold and a terminal-count
// flag asserted when the count reaches Neff-1.
`timescale 1ns/1ps
module clkdiv_phase_counter
   import clkdiv_pkg::*;
#(
   parameter int CNT_WIDTH = 16
)(
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 hold,
   input  logic [CNT_WIDTH-1:0] div,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 tc
);

   assign tc = phase_end(32'(count), 32'(div));

   // Clear wins over hold; otherwise count up by one each cycle.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (!hold)
         count <= count + CNT_WIDTH'(1);
   end

endmodule

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: run-time programmable 50% duty clock divider with
// rise/fall strobes, run/stop, single-step and boundary-only divisor reload.
// Optional feature: define CLKDIV_STRETCH_EN to let 'stretch' extend the high
// phase (wait states); without it the stretch input is ignored.
`timescale 1ns/1ps
module clock_divider_prog
   import clkdiv_pkg::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
)(
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 step,
   input  logic                 div_wr,
   input  logic [CNT_WIDTH-1:0] div_in,
   input  logic                 stretch,
   output logic                 clk_out,
   output logic                 rise_stb,
   output logic                 fall_stb,
   output logic                 running,
   output logic [CNT_WIDTH-1:0] div_active
);

   state_t               state;
   logic                 step_mode;
   logic [CNT_WIDTH-1:0] div_pend;
   logic                 pend_vld;
   logic [CNT_WIDTH-1:0] count;
   logic                 tc;
   logic                 stretch_hold;
   logic                 rise_now;
   logic                 fall_now;
   logic                 cnt_clr;
   logic                 cnt_hold;

`ifdef CLKDIV_STRETCH_EN
   assign stretch_hold = stretch;
`else
   logic unused_stretch;
   assign unused_stretch = stretch;
   assign stretch_hold   = 1'b0;
`endif

   // Phase boundaries; a stretched fall holds the counter at Neff-1.
   assign rise_now = (state == S_LOW)  && tc;
   assign fall_now = (state == S_HIGH) && tc && !stretch_hold;
   assign cnt_hold = (state == S_HIGH) && tc &&  stretch_hold;
   assign cnt_clr  = (state == S_IDLE) || rise_now || fall_now;

   clkdiv_phase_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (cnt_clr),
      .hold   (cnt_hold),
      .div    (div_active),
      .count  (count),
      .tc     (tc)
   );

   // Phase FSM with registered clock, strobes and running flag.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         clk_out   <= 1'b0;
         rise_stb  <= 1'b0;
         fall_stb  <= 1'b0;
         running   <= 1'b0;
         step_mode <= 1'b0;
      end else begin
         rise_stb <= rise_now;
         fall_stb <= fall_now;
         case (state)
            S_IDLE: begin
               clk_out <= 1'b0;
               if (run) begin
                  state   <= S_LOW;
                  running <= 1'b1;
               end else if (step) begin
                  state     <= S_LOW;
                  step_mode <= 1'b1;
                  running   <= 1'b1;
               end
            end
            S_LOW: begin
               if (rise_now) begin
                  clk_out <= 1'b1;
                  state   <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (fall_now) begin
                  clk_out   <= 1'b0;
                  step_mode <= 1'b0;
                  if (run && !step_mode) begin
                     state <= S_LOW;
                  end else begin
                     state   <= S_IDLE;
                     running <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= S_IDLE;
               clk_out <= 1'b0;
               running <= 1'b0;
            end
         endcase
      end
   end

   // Divisor reload: a write at the fall boundary bypasses straight to the
   // active divisor; otherwise it waits in pending until the next fall
   // boundary or the next IDLE cycle, so one period never mixes two divisors.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         div_active <= CNT_WIDTH'(DEFAULT_DIV);
         div_pend   <= '0;
         pend_vld   <= 1'b0;
      end else if (fall_now && div_wr) begin
         div_active <= div_in;
         pend_vld   <= 1'b0;
      end else begin
         if ((fall_now || state == S_IDLE) && pend_vld) begin
            div_active <= div_pend;
            pend_vld   <= 1'b0;
         end
         if (div_wr) begin
            div_pend <= div_in;
            pend_vld <= 1'b1;
         end
      end
   end

endmodule
